// File: rtl/alu_simd_result_unpacker_if.sv
// Bundle for the packed SIMD result unpacker.
// Upstream side:   in_valid/in_ready handshake carrying USE_SIMD, S and
//                  result_SIMD_carry_out (one packed 54-bit ALU word).
// Downstream side: out_valid/out_ready handshake carrying one lane per beat
//                  (out_lane, out_last, out_width, out_data, out_carry,
//                  out_overflow).
// master: the environment (producer of packed words, consumer of lanes).
// slave:  the unpacker itself.
interface alu_simd_result_unpacker_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  USE_SIMD;
  logic [53:0] S;
  logic [23:0] result_SIMD_carry_out;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_lane;
  logic        out_last;
  logic [5:0]  out_width;
  logic [53:0] out_data;
  logic [1:0]  out_carry;
  logic        out_overflow;

  modport master (
    output in_valid, USE_SIMD, S, result_SIMD_carry_out, out_ready,
    input  in_ready, out_valid, out_lane, out_last, out_width, out_data,
           out_carry, out_overflow
  );

  modport slave (
    input  in_valid, USE_SIMD, S, result_SIMD_carry_out, out_ready,
    output in_ready, out_valid, out_lane, out_last, out_width, out_data,
           out_carry, out_overflow
  );
endinterface

// File: rtl/alu_simd_result_unpacker.sv
// Sequential unpacker for the packed 54-bit SIMD ALU result word.
// Captures one packed word (S, per-segment carries, mode) per input
// handshake and emits its lanes one per output beat, least significant lane
// first, right-aligned and zero/sign-extended to 54 bits, with the carry
// pair of the lane's most significant segment.
// Ports:
//   clk      - clock, all state updates on rising edge
//   reset_n  - synchronous active-low reset
//   bus      - slave modport: input word handshake and lane beat handshake
// Parameter:
//   SIGN_EXTEND - 1: replicate lane MSB into upper bits; 0: zero-extend.
module alu_simd_result_unpacker #(
  parameter bit SIGN_EXTEND = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  alu_simd_result_unpacker_if.slave    bus
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t      state_q, state_d;
  logic [53:0] s_q, s_d;
  logic [23:0] c_q, c_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  lane_q, lane_d;

  // Lane geometry for the registered mode and current lane index.
  logic [5:0]  lane_lo;
  logic [5:0]  lane_w;
  logic [3:0]  lane_seg;
  logic [3:0]  last_idx;

  always_comb begin
    lane_lo  = '0;
    lane_w   = 6'd54;
    lane_seg = 4'd11;
    last_idx = '0;
    unique case (mode_q)
      2'b00: begin
        lane_lo  = '0;
        lane_w   = 6'd54;
        lane_seg = 4'd11;
        last_idx = 4'd0;
      end
      2'b01: begin
        last_idx = 4'd2;
        lane_w   = 6'd18;
        lane_seg = {lane_q[1:0], 2'b11};
        case (lane_q)
          4'd0:    lane_lo = 6'd0;
          4'd1:    lane_lo = 6'd18;
          default: lane_lo = 6'd36;
        endcase
      end
      2'b10: begin
        last_idx = 4'd5;
        lane_w   = lane_q[0] ? 6'd10 : 6'd8;
        lane_seg = {lane_q[2:0], 1'b1};
        case (lane_q)
          4'd0:    lane_lo = 6'd0;
          4'd1:    lane_lo = 6'd8;
          4'd2:    lane_lo = 6'd18;
          4'd3:    lane_lo = 6'd26;
          4'd4:    lane_lo = 6'd36;
          default: lane_lo = 6'd44;
        endcase
      end
      default: begin
        last_idx = 4'd11;
        lane_w   = (lane_q[1:0] == 2'd2) ? 6'd6 : 6'd4;
        lane_seg = lane_q;
        case (lane_q)
          4'd0:    lane_lo = 6'd0;
          4'd1:    lane_lo = 6'd4;
          4'd2:    lane_lo = 6'd8;
          4'd3:    lane_lo = 6'd14;
          4'd4:    lane_lo = 6'd18;
          4'd5:    lane_lo = 6'd22;
          4'd6:    lane_lo = 6'd26;
          4'd7:    lane_lo = 6'd32;
          4'd8:    lane_lo = 6'd36;
          4'd9:    lane_lo = 6'd40;
          4'd10:   lane_lo = 6'd44;
          default: lane_lo = 6'd50;
        endcase
      end
    endcase
  end

  // Lane extraction: shift the lane down, then fill everything above the
  // lane width with either zero or the lane's own MSB.
  logic [53:0] shifted;
  logic [5:0]  msb_idx;
  logic        ext_bit;
  logic [53:0] lane_data;
  logic [1:0]  lane_carry;
  logic        is_last;

  always_comb begin
    shifted   = s_q >> lane_lo;
    msb_idx   = lane_w - 6'd1;
    ext_bit   = SIGN_EXTEND & shifted[msb_idx];
    lane_data = '0;
    for (int unsigned b = 0; b < 54; b++) begin
      if (b < 32'(lane_w)) lane_data[b] = shifted[b];
      else                 lane_data[b] = ext_bit;
    end
    lane_carry = 2'(c_q >> {lane_seg, 1'b0});
    is_last    = (lane_q == last_idx);
  end

  // Outputs are only meaningful while emitting; forced to zero otherwise.
  logic        out_valid_c;
  logic [3:0]  out_lane_c;
  logic        out_last_c;
  logic [5:0]  out_width_c;
  logic [53:0] out_data_c;
  logic [1:0]  out_carry_c;
  logic        in_ready_c;

  always_comb begin
    out_valid_c = 1'b0;
    out_lane_c  = '0;
    out_last_c  = 1'b0;
    out_width_c = '0;
    out_data_c  = '0;
    out_carry_c = '0;
    if (state_q == EMIT) begin
      out_valid_c = 1'b1;
      out_lane_c  = lane_q;
      out_last_c  = is_last;
      out_width_c = lane_w;
      out_data_c  = lane_data;
      out_carry_c = lane_carry;
    end
    // Accepting during the final beat's handshake removes the bubble between
    // words; held low while reset is asserted.
    in_ready_c = reset_n &
                 ((state_q == IDLE) ||
                  ((state_q == EMIT) && is_last && bus.out_ready));
  end

  assign bus.out_valid    = out_valid_c;
  assign bus.out_lane     = out_lane_c;
  assign bus.out_last     = out_last_c;
  assign bus.out_width    = out_width_c;
  assign bus.out_data     = out_data_c;
  assign bus.out_carry    = out_carry_c;
  assign bus.out_overflow = |out_carry_c;
  assign bus.in_ready     = in_ready_c;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    mode_d  = mode_q;
    lane_d  = lane_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.S;
          c_d     = bus.result_SIMD_carry_out;
          mode_d  = bus.USE_SIMD;
          lane_d  = '0;
          state_d = EMIT;
        end
      end
      default: begin
        if (bus.out_ready) begin
          if (!is_last) begin
            lane_d = lane_q + 4'd1;
          end else if (bus.in_valid) begin
            s_d    = bus.S;
            c_d    = bus.result_SIMD_carry_out;
            mode_d = bus.USE_SIMD;
            lane_d = '0;
          end else begin
            lane_d  = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      mode_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: tb/tb_alu_simd_result_unpacker.sv
module tb_alu_simd_result_unpacker;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for two instances (zero- and sign-extending).
  logic        in_valid = 1'b0;
  logic [1:0]  use_simd = '0;
  logic [53:0] s_in = '0;
  logic [23:0] c_in = '0;
  logic        out_ready = 1'b1;
  int unsigned ready_mode = 0; // 0 always, 1 toggle, 2 random

  alu_simd_result_unpacker_if if0 ();
  alu_simd_result_unpacker_if if1 ();

  assign if0.in_valid = in_valid;
  assign if0.USE_SIMD = use_simd;
  assign if0.S = s_in;
  assign if0.result_SIMD_carry_out = c_in;
  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;
  assign if1.USE_SIMD = use_simd;
  assign if1.S = s_in;
  assign if1.result_SIMD_carry_out = c_in;
  assign if1.out_ready = out_ready;

  alu_simd_result_unpacker #(.SIGN_EXTEND(1'b0)) u_zx (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  alu_simd_result_unpacker #(.SIGN_EXTEND(1'b1)) u_sx (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned w;
    logic [53:0] data;
    logic [1:0]  carry;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  mode;
    logic [53:0] s;
    logic [23:0] c;
    int unsigned k;
  } item_t;

  item_t q[$];

  function automatic int unsigned nlanes(logic [1:0] m);
    case (m)
      2'd0: return 1;
      2'd1: return 3;
      2'd2: return 6;
      default: return 12;
    endcase
  endfunction

  function automatic int unsigned lane_width(logic [1:0] m, int unsigned k);
    case (m)
      2'd0: return 54;
      2'd1: return 18;
      2'd2: return (k % 2 == 1) ? 10 : 8;
      default: return (k % 4 == 2) ? 6 : 4;
    endcase
  endfunction

  function automatic beat_t model_beat(logic [1:0] m, logic [53:0] s,
                                       logic [23:0] c, int unsigned k, bit se);
    beat_t r;
    int unsigned off = 0;
    int unsigned msb, seg = 0, soff = 0, sw;
    logic [63:0] v, mask;
    for (int unsigned j = 0; j < k; j++) off += lane_width(m, j);
    r.w = lane_width(m, k);
    msb = off + r.w - 1;
    // carry comes from whichever segment holds the lane's MSB
    for (int unsigned j = 0; j < 12; j++) begin
      sw = (j % 4 == 2) ? 6 : 4;
      if (msb >= soff && msb < soff + sw) seg = j;
      soff += sw;
    end
    mask = (64'd1 << r.w) - 64'd1;
    v = (64'(s) >> off) & mask;
    if (se && r.w < 54 && v[r.w-1]) v = v | ~mask;
    r.data  = v[53:0];
    r.carry = 2'((c >> (2 * seg)) & 24'd3);
    r.last  = (k == nlanes(m) - 1);
    return r;
  endfunction

  task automatic check_beat(string tag, logic ov, logic [3:0] ol, logic olast,
                            logic [5:0] ow, logic [53:0] od, logic [1:0] oc,
                            logic oo, item_t it, bit se);
    beat_t e;
    e = model_beat(it.mode, it.s, it.c, it.k, se);
    chk({tag, "_valid"}, 64'(ov), 64'd1);
    chk({tag, "_lane"}, 64'(ol), 64'(it.k));
    chk({tag, "_last"}, 64'(olast), 64'(e.last));
    chk({tag, "_width"}, 64'(ow), 64'(e.w));
    chk({tag, "_data"}, 64'(od), 64'(e.data));
    chk({tag, "_carry"}, 64'(oc), 64'(e.carry));
    chk({tag, "_ovf"}, 64'(oo), 64'(|e.carry));
  endtask

  // reset level seen at the most recent rising edge
  logic rst_sampled = 1'b1;
  always @(posedge clk) rst_sampled = reset_n;

  // ---------------- compare process ----------------
  initial begin
    logic exp_ready;
    forever begin
      @(negedge clk);
      if (!rst_sampled) begin
        chk("rst_zx_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_zx_lane", 64'(if0.out_lane), 64'd0);
        chk("rst_zx_last", 64'(if0.out_last), 64'd0);
        chk("rst_zx_width", 64'(if0.out_width), 64'd0);
        chk("rst_zx_data", 64'(if0.out_data), 64'd0);
        chk("rst_zx_carry", 64'(if0.out_carry), 64'd0);
        chk("rst_zx_ovf", 64'(if0.out_overflow), 64'd0);
        chk("rst_sx_valid", 64'(if1.out_valid), 64'd0);
        chk("rst_sx_data", 64'(if1.out_data), 64'd0);
      end
      if (!reset_n) begin
        chk("rst_in_ready_zx", 64'(if0.in_ready), 64'd0);
        chk("rst_in_ready_sx", 64'(if1.in_ready), 64'd0);
        q.delete();
      end else begin
        exp_ready = (q.size() == 0) ||
                    ((q[0].k == nlanes(q[0].mode) - 1) && out_ready);
        chk("in_ready_zx", 64'(if0.in_ready), 64'(exp_ready));
        chk("in_ready_sx", 64'(if1.in_ready), 64'(exp_ready));
        if (q.size() == 0) begin
          chk("idle_valid_zx", 64'(if0.out_valid), 64'd0);
          chk("idle_valid_sx", 64'(if1.out_valid), 64'd0);
        end else begin
          check_beat("zx", if0.out_valid, if0.out_lane, if0.out_last,
                     if0.out_width, if0.out_data, if0.out_carry,
                     if0.out_overflow, q[0], 1'b0);
          check_beat("sx", if1.out_valid, if1.out_lane, if1.out_last,
                     if1.out_width, if1.out_data, if1.out_carry,
                     if1.out_overflow, q[0], 1'b1);
          if (out_ready) void'(q.pop_front());
        end
        if (in_valid && exp_ready) begin
          for (int unsigned k = 0; k < nlanes(use_simd); k++) begin
            item_t it;
            it.mode = use_simd; it.s = s_in; it.c = c_in; it.k = k;
            q.push_back(it);
          end
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(logic [1:0] m, logic [53:0] s, logic [23:0] c);
    int unsigned n = 0;
    in_valid = 1'b1; use_simd = m; s_in = s; c_in = c;
    forever begin
      @(negedge clk);
      if (if0.in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    in_valid = 1'b0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        chk("drain_timeout", 64'(q.size()), 64'd0);
        q.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [53:0] rnd54();
    return {22'($urandom), $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [53:0] s9, s4, tmp;
    beat_t b;

    // Pin the model with hand-computed values.
    s9 = {18'h3FFFF, 18'h00005, 18'h20000};
    b = model_beat(2'd1, s9, '0, 0, 1'b1);
    chk("model_9x9_l0", 64'(b.data), 64'h3F_FFFF_FFFE_0000);
    b = model_beat(2'd1, s9, '0, 1, 1'b1);
    chk("model_9x9_l1", 64'(b.data), 64'h5);
    b = model_beat(2'd1, s9, '0, 2, 1'b1);
    chk("model_9x9_l2", 64'(b.data), 64'h3F_FFFF_FFFF_FFFF);
    b = model_beat(2'd0, 54'h20_0000_0000_0001, 24'h400000, 0, 1'b0);
    chk("model_27_data", 64'(b.data), 64'h20_0000_0000_0001);
    chk("model_27_carry", 64'(b.carry), 64'd1);
    s4 = 54'h12_3456_789A_BCDE;
    b = model_beat(2'd2, s4, 24'h00000C, 0, 1'b0);
    chk("model_4x4_l0_carry", 64'(b.carry), 64'd3);
    b = model_beat(2'd2, s4, 24'h0, 1, 1'b0);
    chk("model_4x4_l1_data", 64'(b.data), 64'h2BC);
    chk("model_4x4_l1_w", 64'(b.w), 64'd10);
    b = model_beat(2'd3, s4, 24'h000020, 2, 1'b0);
    chk("model_2x2_l2_w", 64'(b.w), 64'd6);
    chk("model_2x2_l2_data", 64'(b.data), 64'h3C);
    chk("model_2x2_l2_carry", 64'(b.carry), 64'd2);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // 27x27 single beat
    ready_mode = 0;
    send_word(2'd0, 54'h20_0000_0000_0001, 24'h400000);
    drain();

    // sum_9x9
    send_word(2'd1, s9, 24'h8C_3000);
    drain();

    // sum_4x4 with stalls
    ready_mode = 1;
    send_word(2'd2, s4, 24'hE4_E4E4);
    drain();
    ready_mode = 0;
    @(posedge clk); #1;

    // sum_2x2 back-to-back
    send_word(2'd3, rnd54(), 24'($urandom));
    send_word(2'd3, rnd54(), 24'($urandom));
    drain();

    // mode change during emission
    send_word(2'd2, rnd54(), 24'($urandom));
    in_valid = 1'b0;
    @(posedge clk); #1;
    use_simd = 2'd0;
    drain();

    // reset mid-word after three beats
    send_word(2'd3, rnd54(), 24'($urandom));
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tmp = rnd54();
    send_word(2'd1, tmp, 24'($urandom));
    drain();

    // randomized traffic
    ready_mode = 2;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk); #1;
        end
      end
      send_word(2'($urandom), rnd54(), 24'($urandom));
    end
    drain();
    ready_mode = 0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
